sdram_ch3_arbiter: RTL and testbench

- Shares the SDRAM controller's read/write channel 3 among three client ports, using round-robin arbitration.
- Clients use a level req / 1-cycle ack-pulse handshake. The SDRAM side uses the controller's toggle handshake (req toggles; done when ack == req).
- Holds one 64-bit read line (4 words, 8-byte aligned). Read hits return without an SDRAM access.
- Writes are write-through. Sits between the CPU, sprite and tilemap RAM clients and the sdram channel 3 port.

---
 rtl/sdram_ch3_arbiter.sv | 147 ++++++++++++++
 tb/tb_sdram_ch3_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_ch3_arbiter.sv
// sdram_ch3_arbiter: round-robin arbiter sharing SDRAM channel 3 among three clients, with a one-line read buffer
module sdram_ch3_arbiter #(
  parameter int LINE_EN = 1,
  parameter int SYNC_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        c0_req,
  input  logic [26:0] c0_addr,
  input  logic        c0_we,
  input  logic [15:0] c0_din,
  input  logic [1:0]  c0_be,
  output logic [15:0] c0_dout,
  output logic        c0_ack,
  input  logic        c1_req,
  input  logic [26:0] c1_addr,
  input  logic        c1_we,
  input  logic [15:0] c1_din,
  input  logic [1:0]  c1_be,
  output logic [15:0] c1_dout,
  output logic        c1_ack,
  input  logic        c2_req,
  input  logic [26:0] c2_addr,
  input  logic        c2_we,
  input  logic [15:0] c2_din,
  input  logic [1:0]  c2_be,
  output logic [15:0] c2_dout,
  output logic        c2_ack,
  output logic        sd_req,
  output logic [26:0] sd_addr,
  output logic        sd_rnw,
  output logic [15:0] sd_din,
  output logic [1:0]  sd_be,
  input  logic [63:0] sd_dout,
  input  logic        sd_ack
);
  typedef enum logic [1:0] {RESYNC, IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [2:0] req, we, ack;
  logic [26:0] addr [3];
  logic [15:0] din [3];
  logic [1:0] be [3];
  logic [15:0] dout [3];
  logic [1:0] rr, cur, p1, p2, gnt;
  logic [26:0] g_addr;
  logic g_we;
  logic [15:0] g_din;
  logic [1:0] g_be;
  logic [26:1] a_q;
  logic [7:0] cnt;
  logic [63:0] line;
  logic [23:0] tag;
  logic line_valid, tag_hit, rd_hit, done, sync_done;
  logic [15:0] old_w, mrg_w;
  assign req = {c2_req, c1_req, c0_req};
  assign we = {c2_we, c1_we, c0_we};
  assign addr[0] = c0_addr;
  assign addr[1] = c1_addr;
  assign addr[2] = c2_addr;
  assign din[0] = c0_din;
  assign din[1] = c1_din;
  assign din[2] = c2_din;
  assign be[0] = c0_be;
  assign be[1] = c1_be;
  assign be[2] = c2_be;
  assign c0_ack = ack[0];
  assign c1_ack = ack[1];
  assign c2_ack = ack[2];
  assign c0_dout = dout[0];
  assign c1_dout = dout[1];
  assign c2_dout = dout[2];
  always_comb begin
    p1 = (rr == 2'd2) ? 2'd0 : rr + 2'd1;
    p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
    gnt = req[p1] ? p1 : req[p2] ? p2 : rr;
    g_addr = addr[gnt];
    g_we = we[gnt];
    g_din = din[gnt];
    g_be = be[gnt];
    tag_hit = (LINE_EN != 0) && line_valid && (g_addr[26:3] == tag);
    rd_hit = tag_hit && !g_we;
    old_w = line[{g_addr[2:1], 4'd0} +: 16];
    mrg_w = {g_be[1] ? g_din[15:8] : old_w[15:8], g_be[0] ? g_din[7:0] : old_w[7:0]};
    done = sd_ack == sd_req;
    sync_done = cnt == 8'(SYNC_CYCLES - 1);
    state_nxt = state == RESYNC ? (sync_done ? IDLE : RESYNC) :
                state == IDLE   ? ((|req) ? (rd_hit ? RESP : WAIT) : IDLE) :
                state == WAIT   ? (done ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk)
    state <= reset ? RESYNC : state_nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      ack <= '0;
      dout <= '{default: '0};
      sd_req <= sd_ack;
      sd_addr <= '0;
      sd_rnw <= 1'b1;
      sd_din <= '0;
      sd_be <= '0;
      line_valid <= 1'b0;
      line <= '0;
      tag <= '0;
      rr <= 2'd2;
      cur <= 2'd0;
      a_q <= '0;
      cnt <= '0;
    end else begin
      ack <= '0;
      if (state == RESYNC) begin
        sd_req <= sd_ack;
        cnt <= cnt + 8'd1;
      end
      if (state == IDLE && (|req)) begin
        rr <= gnt;
        cur <= gnt;
        a_q <= g_addr[26:1];
        if (rd_hit) begin
          ack[gnt] <= 1'b1;
          dout[gnt] <= old_w;
        end else begin
          sd_req <= ~sd_req;
          sd_addr <= g_we ? g_addr : {g_addr[26:3], 3'b000};
          sd_rnw <= ~g_we;
          if (g_we) begin
            sd_din <= g_din;
            sd_be <= g_be;
          end
          if (tag_hit && g_we)
            line[{g_addr[2:1], 4'd0} +: 16] <= mrg_w;
        end
      end
      if (state == WAIT && done) begin
        ack[cur] <= 1'b1;
        if (sd_rnw) begin
          dout[cur] <= sd_dout[{a_q[2:1], 4'd0} +: 16];
          line <= sd_dout;
          tag <= a_q[26:3];
          line_valid <= LINE_EN != 0;
        end
      end
      if (flush)
        line_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sdram_ch3_arbiter.sv
// tb_sdram_ch3_arbiter: directed vector bench with a toggle-handshake SDRAM channel model
module tb_sdram_ch3_arbiter;
  typedef struct {
    int c;
    logic [26:0] a;
    logic w;
    logic [15:0] d;
    logic [1:0] b;
    logic [63:0] md;
    logic [15:0] exp;
    int tx;
    logic [26:0] sda;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic [2:0] req = '0;
  logic [2:0] we = '0;
  logic [26:0] addr [3];
  logic [15:0] din [3];
  logic [1:0] be [3];
  logic [15:0] dout [3];
  logic [2:0] ack;
  logic sd_req, sd_rnw;
  logic sd_ack = 1'b0;
  logic [26:0] sd_addr;
  logic [15:0] sd_din;
  logic [1:0] sd_be;
  logic [63:0] sd_dout = '0;
  int checks = 0;
  int failures = 0;
  int lat = 3;
  int m_cnt = 0;
  int n_tx = 0;
  logic m_tgt = 1'b0;
  logic [63:0] m_data = '0;
  logic [26:0] l_addr = '0;
  logic l_rnw = 1'b0;
  logic [15:0] l_din = '0;
  logic [1:0] l_be = '0;
  int ord [3];
  vec_t v [12];
  sdram_ch3_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .c0_req(req[0]), .c0_addr(addr[0]), .c0_we(we[0]), .c0_din(din[0]), .c0_be(be[0]), .c0_dout(dout[0]), .c0_ack(ack[0]),
    .c1_req(req[1]), .c1_addr(addr[1]), .c1_we(we[1]), .c1_din(din[1]), .c1_be(be[1]), .c1_dout(dout[1]), .c1_ack(ack[1]),
    .c2_req(req[2]), .c2_addr(addr[2]), .c2_we(we[2]), .c2_din(din[2]), .c2_be(be[2]), .c2_dout(dout[2]), .c2_ack(ack[2]),
    .sd_req(sd_req), .sd_addr(sd_addr), .sd_rnw(sd_rnw), .sd_din(sd_din), .sd_be(sd_be),
    .sd_dout(sd_dout), .sd_ack(sd_ack)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (m_cnt != 0) begin
      if (m_cnt == 2) begin
        sd_ack <= m_tgt;
        sd_dout <= m_data;
      end
      m_cnt <= m_cnt - 1;
    end else if (sd_req != sd_ack) begin
      m_cnt <= lat + 1;
      m_tgt <= sd_req;
      n_tx <= n_tx + 1;
      l_addr <= sd_addr;
      l_rnw <= sd_rnw;
      l_din <= sd_din;
      l_be <= sd_be;
    end
  end
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask
  task automatic access(input int c, input logic [26:0] a, input logic w, input logic [15:0] d,
                        input logic [1:0] b, output int k, output logic [15:0] q);
    req[c] = 1'b1;
    addr[c] = a;
    we[c] = w;
    din[c] = d;
    be[c] = b;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ack[c] && k < 200);
    chk("ack_seen", ack[c], 1);
    q = dout[c];
    req[c] = 1'b0;
    @(negedge clk);
    chk("ack_pulse", ack[c], 0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_dout", {dout[0], dout[1], dout[2]}, 0);
    chk("rst_sd", {sd_addr, sd_din, sd_be}, 0);
    chk("rst_rnw", sd_rnw, 1);
    chk("rst_sync", sd_req, sd_ack);
    reset = 1'b0;
  endtask
  task automatic run_multi();
    int n = 0;
    int k = 0;
    ord = '{-1, -1, -1};
    req = 3'b111;
    while (n < 3 && k < 400) begin
      @(negedge clk);
      k++;
      for (int j = 0; j < 3; j++)
        if (ack[j]) begin
          if (n < 3) ord[n] = j;
          n++;
          req[j] = 1'b0;
        end
    end
    chk("multi_done", n, 3);
  endtask
  initial begin
    int k, n0, n;
    logic [15:0] q;
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0;
      din[i] = '0;
      be[i] = '0;
    end
    v[0]  = '{0, 27'h100, 1'b0, 16'h0,    2'b00, 64'h4444_3333_2222_1111, 16'h1111, 1, 27'h100};
    v[1]  = '{1, 27'h106, 1'b0, 16'h0,    2'b00, 64'h4444_3333_2222_1111, 16'h4444, 0, 27'h0};
    v[2]  = '{2, 27'h102, 1'b1, 16'hABCD, 2'b01, 64'h4444_3333_2222_1111, 16'h0000, 1, 27'h102};
    v[3]  = '{0, 27'h102, 1'b0, 16'h0,    2'b00, 64'h4444_3333_2222_1111, 16'h22CD, 0, 27'h0};
    v[4]  = '{1, 27'h100, 1'b0, 16'h0,    2'b00, 64'h4444_3333_2222_1111, 16'h1111, 0, 27'h0};
    v[5]  = '{2, 27'h104, 1'b1, 16'h1234, 2'b11, 64'h4444_3333_2222_1111, 16'h0000, 1, 27'h104};
    v[6]  = '{1, 27'h104, 1'b0, 16'h0,    2'b00, 64'h4444_3333_2222_1111, 16'h1234, 0, 27'h0};
    v[7]  = '{0, 27'h10A, 1'b0, 16'h0,    2'b00, 64'h8888_7777_6666_5555, 16'h6666, 1, 27'h108};
    v[8]  = '{2, 27'h100, 1'b0, 16'h0,    2'b00, 64'h4444_1234_22CD_1111, 16'h1111, 1, 27'h100};
    v[9]  = '{2, 27'h106, 1'b0, 16'h0,    2'b00, 64'h4444_1234_22CD_1111, 16'h4444, 0, 27'h0};
    v[10] = '{1, 27'h10E, 1'b1, 16'h5A5A, 2'b10, 64'h4444_1234_22CD_1111, 16'h1234, 1, 27'h10E};
    v[11] = '{0, 27'h10E, 1'b0, 16'h0,    2'b00, 64'h5A55_7777_6666_5555, 16'h5A55, 1, 27'h108};
    do_reset();
    m_data = 64'hDEAD_BEEF_CAFE_F00D;
    n0 = n_tx;
    access(0, 27'h300, 1'b0, 16'h0, 2'b00, k, q);
    chk("resync_blocks_grant", k > 16, 1);
    chk("first_dout", q, 16'hF00D);
    chk("first_tx", n_tx - n0, 1);
    for (int i = 0; i < 12; i++) begin
      m_data = v[i].md;
      n0 = n_tx;
      access(v[i].c, v[i].a, v[i].w, v[i].d, v[i].b, k, q);
      chk($sformatf("row%0d_dout", i), q, v[i].exp);
      chk($sformatf("row%0d_tx", i), n_tx - n0, v[i].tx);
      if (v[i].tx == 0)
        chk($sformatf("row%0d_hit_lat", i), k, 1);
      else begin
        chk($sformatf("row%0d_sd_addr", i), l_addr, v[i].sda);
        chk($sformatf("row%0d_sd_rnw", i), l_rnw, !v[i].w);
        if (v[i].w)
          chk($sformatf("row%0d_sd_wdata", i), {l_din, l_be}, {v[i].d, v[i].b});
      end
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_data = 64'h5A55_7777_6666_5555;
    n0 = n_tx;
    access(0, 27'h10C, 1'b0, 16'h0, 2'b00, k, q);
    chk("flush_miss_tx", n_tx - n0, 1);
    chk("flush_miss_dout", q, 16'h7777);
    m_data = 64'h4444_1234_22CD_1111;
    n0 = n_tx;
    req[1] = 1'b1;
    addr[1] = 27'h100;
    we[1] = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      flush = (n_tx != n0 && sd_ack == sd_req) || ack[1];
    end while (!ack[1] && k < 200);
    chk("fill_flush_ack", ack[1], 1);
    chk("fill_flush_dout", dout[1], 16'h1111);
    req[1] = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    n0 = n_tx;
    access(2, 27'h106, 1'b0, 16'h0, 2'b00, k, q);
    chk("after_fill_flush_tx", n_tx - n0, 1);
    chk("after_fill_flush_dout", q, 16'h4444);
    n0 = n_tx;
    access(0, 27'h100, 1'b0, 16'h0, 2'b00, k, q);
    chk("refill_hit_tx", n_tx - n0, 0);
    chk("refill_hit_dout", q, 16'h1111);
    lat = 5;
    m_data = 64'h0;
    n0 = n_tx;
    req[0] = 1'b1;
    addr[0] = 27'h200;
    we[0] = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (n_tx == n0 && k < 50);
    chk("wait_tx", n_tx - n0, 1);
    chk("wait_pending", sd_req != sd_ack, 1);
    req[0] = 1'b0;
    do_reset();
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack != 0) n++;
    end
    chk("dropped_ack", n, 0);
    chk("no_spurious_req", n_tx - n0, 1);
    chk("idle_sync", sd_req, sd_ack);
    lat = 3;
    m_data = 64'h1357_2468_ACE0_BDF1;
    n0 = n_tx;
    access(0, 27'h204, 1'b0, 16'h0, 2'b00, k, q);
    chk("post_reset_dout", q, 16'h2468);
    chk("post_reset_tx", n_tx - n0, 1);
    chk("post_reset_addr", l_addr, 27'h200);
    do_reset();
    for (int j = 0; j < 3; j++) begin
      addr[j] = 27'h1000 * (j + 1);
      we[j] = 1'b0;
    end
    run_multi();
    chk("rr0_first", ord[0], 0);
    chk("rr0_second", ord[1], 1);
    chk("rr0_third", ord[2], 2);
    access(0, 27'h4000, 1'b0, 16'h0, 2'b00, k, q);
    addr[0] = 27'h7000;
    addr[1] = 27'h5000;
    addr[2] = 27'h6000;
    run_multi();
    chk("rr1_first", ord[0], 1);
    chk("rr1_second", ord[1], 2);
    chk("rr1_third", ord[2], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
